// File: rtl/bram_result_display_pkg.sv
// Shared definitions for the BRAM result display: glyphs, blank codes, pipeline entry.
package bram_result_display_pkg;

  localparam int unsigned DATA_W   = 16;
  localparam int unsigned NIB_W    = 4;
  localparam int unsigned SEG_W    = 7;
  localparam int unsigned DIGITS   = 4;
  localparam int unsigned DIGIT_W  = 2;
  localparam int unsigned CCOUNT_W = 4;

  // Active-low glyphs, bit order {g,f,e,d,c,b,a}
  localparam logic [SEG_W-1:0] SEG_0 = 7'h40;
  localparam logic [SEG_W-1:0] SEG_1 = 7'h79;
  localparam logic [SEG_W-1:0] SEG_2 = 7'h24;
  localparam logic [SEG_W-1:0] SEG_3 = 7'h30;
  localparam logic [SEG_W-1:0] SEG_4 = 7'h19;
  localparam logic [SEG_W-1:0] SEG_5 = 7'h12;
  localparam logic [SEG_W-1:0] SEG_6 = 7'h02;
  localparam logic [SEG_W-1:0] SEG_7 = 7'h78;
  localparam logic [SEG_W-1:0] SEG_8 = 7'h00;
  localparam logic [SEG_W-1:0] SEG_9 = 7'h10;
  localparam logic [SEG_W-1:0] SEG_A = 7'h08;
  localparam logic [SEG_W-1:0] SEG_B = 7'h03;
  localparam logic [SEG_W-1:0] SEG_C = 7'h46;
  localparam logic [SEG_W-1:0] SEG_D = 7'h21;
  localparam logic [SEG_W-1:0] SEG_E = 7'h06;
  localparam logic [SEG_W-1:0] SEG_F = 7'h0E;

  localparam logic [SEG_W-1:0]  SEG_BLANK = 7'h7F;
  localparam logic [DIGITS-1:0] AN_OFF    = 4'hF;

  // One slot of the capture delay line
  typedef struct packed {
    logic cap;
    logic sel;
  } cap_entry_t;

endpackage

// File: rtl/bram_result_display_if.sv
// BRAM read-side inputs and display-side outputs of the result display.
interface bram_result_display_if;
  import bram_result_display_pkg::*;

  logic [DATA_W-1:0]   dataOutA;
  logic [DATA_W-1:0]   dataOutB;
  logic                displaySelect;
  logic                capture;
  logic [SEG_W-1:0]    seg;
  logic [DIGITS-1:0]   an;
  logic [DATA_W-1:0]   held;
  logic                valid;
  logic [CCOUNT_W-1:0] capCount;

  modport master (
    output dataOutA, dataOutB, displaySelect, capture,
    input  seg, an, held, valid, capCount
  );

  modport slave (
    input  dataOutA, dataOutB, displaySelect, capture,
    output seg, an, held, valid, capCount
  );

endinterface

// File: rtl/bram_result_display_hex_to_seg7.sv
// Combinational hex nibble to active-low 7-segment glyph decoder.
module hex_to_seg7
  import bram_result_display_pkg::*;
(
  input  logic [NIB_W-1:0] nibble,
  output logic [SEG_W-1:0] seg_c
);

  // Glyph lookup
  always_comb begin
    seg_c = SEG_BLANK;
    case (nibble)
      4'h0: seg_c = SEG_0;
      4'h1: seg_c = SEG_1;
      4'h2: seg_c = SEG_2;
      4'h3: seg_c = SEG_3;
      4'h4: seg_c = SEG_4;
      4'h5: seg_c = SEG_5;
      4'h6: seg_c = SEG_6;
      4'h7: seg_c = SEG_7;
      4'h8: seg_c = SEG_8;
      4'h9: seg_c = SEG_9;
      4'hA: seg_c = SEG_A;
      4'hB: seg_c = SEG_B;
      4'hC: seg_c = SEG_C;
      4'hD: seg_c = SEG_D;
      4'hE: seg_c = SEG_E;
      default: seg_c = SEG_F;
    endcase
  end

endmodule

// File: rtl/bram_result_display.sv
// Captures a BRAM read word after the read latency and scans it onto a 4-digit display.
module bram_result_display
  import bram_result_display_pkg::*;
#(
  parameter int unsigned READ_LAT    = 1,
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned BLANK_LZ    = 1
) (
  input logic clk,
  input logic rst,
  bram_result_display_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  cap_entry_t            pipe_q [READ_LAT];
  logic [DATA_W-1:0]     held_q;
  logic                  valid_q;
  logic [CCOUNT_W-1:0]   cap_count_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [DIGIT_W-1:0]    digit_q;
  logic [SEG_W-1:0]      seg_q;
  logic [DIGITS-1:0]     an_q;

  logic [NIB_W-1:0]      nibble_c;
  logic [SEG_W-1:0]      glyph_c;
  logic                  blank_c;
  logic [SEG_W-1:0]      seg_d;
  logic [DIGITS-1:0]     an_d;
  cap_entry_t            done_c;

  assign done_c = pipe_q[READ_LAT-1];

  // Delay line carrying each strobe and its sampled select for READ_LAT cycles
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < READ_LAT; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= '{cap: bus.capture, sel: bus.displaySelect};
      for (int unsigned i = 1; i < READ_LAT; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  // Land the read word from the port chosen when the strobe was issued
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      held_q      <= '0;
      valid_q     <= 1'b0;
      cap_count_q <= '0;
    end else if (done_c.cap) begin
      held_q      <= done_c.sel ? bus.dataOutB : bus.dataOutA;
      valid_q     <= 1'b1;
      cap_count_q <= cap_count_q + CCOUNT_W'(1);
    end
  end

  // Refresh divider stepping the active digit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q   <= '0;
      digit_q <= '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_q   <= '0;
      digit_q <= digit_q + DIGIT_W'(1);
    end else begin
      cnt_q   <= cnt_q + CNT_W'(1);
    end
  end

  assign nibble_c = held_q[{digit_q, 2'b00} +: NIB_W];

  hex_to_seg7 u_hex (
    .nibble (nibble_c),
    .seg_c  (glyph_c)
  );

  // Leading-zero detect: this digit and every higher one are zero
  always_comb begin
    blank_c = 1'b0;
    case (digit_q)
      2'd1:    blank_c = (held_q[15:4]  == 12'h000);
      2'd2:    blank_c = (held_q[15:8]  == 8'h00);
      2'd3:    blank_c = (held_q[15:12] == 4'h0);
      default: blank_c = 1'b0;
    endcase
  end

  // Digit mux with blanking
  always_comb begin
    seg_d = SEG_BLANK;
    an_d  = AN_OFF;
    if (valid_q) begin
      an_d  = ~(DIGITS'(1) << digit_q);
      seg_d = glyph_c;
      if ((BLANK_LZ != 0) && blank_c) begin
        an_d  = AN_OFF;
        seg_d = SEG_BLANK;
      end
    end
  end

  // Registered display drive
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seg_q <= SEG_BLANK;
      an_q  <= AN_OFF;
    end else begin
      seg_q <= seg_d;
      an_q  <= an_d;
    end
  end

  assign bus.seg      = seg_q;
  assign bus.an       = an_q;
  assign bus.held     = held_q;
  assign bus.valid    = valid_q;
  assign bus.capCount = cap_count_q;

endmodule
